// File: rtl/lab1_imul_pkg.sv
// Shared definitions for the variable-latency multiplier: FSM state encoding
// and helpers that locate the request message fields for a given operand width.
package lab1_imul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Request message layout: {signed_mode, a, b}
  function automatic int msg_mode_idx(input int nbits);
    return 2 * nbits;
  endfunction

  function automatic int msg_a_msb(input int nbits);
    return 2 * nbits - 1;
  endfunction

  function automatic int msg_a_lsb(input int nbits);
    return nbits;
  endfunction

  function automatic int msg_b_msb(input int nbits);
    return nbits - 1;
  endfunction

endpackage

// File: rtl/lab1_imul_tz_count.sv
// Trailing-zero count of the remaining multiplier bits, saturating at MAX_SKIP
// so one CALC cycle never shifts further than the skip limit.
module lab1_imul_tz_count
  import lab1_imul_pkg::*;
#(
  parameter int NBITS    = 32,
  parameter int MAX_SKIP = 8,
  parameter int KW       = $clog2(MAX_SKIP + 1)
) (
  input  logic [NBITS-1:0] b_i,
  output logic [KW-1:0]    k_o
);

  logic found_s;

  // First set bit among the low MAX_SKIP bits wins; none set means a full skip.
  always_comb begin
    k_o     = KW'(MAX_SKIP);
    found_s = 1'b0;
    for (int i = 0; i < MAX_SKIP; i++) begin
      if (!found_s && b_i[i]) begin
        k_o     = KW'(i);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/vc_SimpleAdder.sv
// Plain modular adder shared by the accumulate and final-negate steps.
module vc_SimpleAdder #(
  parameter int nbits = 32
) (
  input  logic [nbits-1:0] in0,
  input  logic [nbits-1:0] in1,
  output logic [nbits-1:0] out
);

  assign out = in0 + in1;

endmodule

// File: rtl/lab1_imul_int_mul_var_param.sv
// Variable-latency shift-add multiplier: one partial product or one zero-run
// skip per CALC cycle, full 2*NBITS product, signed or unsigned per request.
module lab1_imul_int_mul_var_param
  import lab1_imul_pkg::*;
#(
  parameter int NBITS    = 32,
  parameter int MAX_SKIP = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             istream_val,
  output logic             istream_rdy,
  input  logic [2*NBITS:0] istream_msg,
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic [2*NBITS-1:0] ostream_msg
);

  localparam int W        = 2 * NBITS;
  localparam int KW       = $clog2(MAX_SKIP + 1);
  localparam int MODE_IDX = msg_mode_idx(NBITS);
  localparam int A_MSB    = msg_a_msb(NBITS);
  localparam int A_LSB    = msg_a_lsb(NBITS);
  localparam int B_MSB    = msg_b_msb(NBITS);

  state_e           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     a_q, a_d;
  logic [NBITS-1:0] b_q, b_d;
  logic             neg_q, neg_d;

  logic             mode_s;
  logic [NBITS-1:0] a_in_s, b_in_s, a_mag_s, b_mag_s;
  logic [W-1:0]     add_in0_s, add_in1_s, sum_s;
  logic [KW-1:0]    k_s;

  assign mode_s = istream_msg[MODE_IDX];
  assign a_in_s = istream_msg[A_MSB:A_LSB];
  assign b_in_s = istream_msg[B_MSB:0];

  // -2^(NBITS-1) negates to itself, which is already the correct unsigned magnitude.
  assign a_mag_s = (mode_s && a_in_s[NBITS-1]) ? (~a_in_s + NBITS'(1)) : a_in_s;
  assign b_mag_s = (mode_s && b_in_s[NBITS-1]) ? (~b_in_s + NBITS'(1)) : b_in_s;

  lab1_imul_tz_count #(.NBITS(NBITS), .MAX_SKIP(MAX_SKIP), .KW(KW)) u_tz (
    .b_i (b_q),
    .k_o (k_s)
  );

  vc_SimpleAdder #(.nbits(W)) u_add (
    .in0 (add_in0_s),
    .in1 (add_in1_s),
    .out (sum_s)
  );

  assign istream_rdy = reset && (state_q == IDLE);
  assign ostream_val = reset && (state_q == DONE);
  assign ostream_msg = acc_q;

  // Next-state and datapath control; the adder either accumulates a_q or forms ~acc+1.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_d     = neg_q;
    add_in0_s = acc_q;
    add_in1_s = a_q;
    case (state_q)
      IDLE: begin
        if (istream_val) begin
          a_d     = W'(a_mag_s);
          b_d     = b_mag_s;
          neg_d   = mode_s & (a_in_s[NBITS-1] ^ b_in_s[NBITS-1]);
          acc_d   = {W{1'b0}};
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (b_q == {NBITS{1'b0}}) begin
          add_in0_s = neg_q ? ~acc_q : acc_q;
          add_in1_s = neg_q ? W'(1) : {W{1'b0}};
          acc_d     = sum_s;
          state_d   = DONE;
        end else if (b_q[0]) begin
          acc_d = sum_s;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end else begin
          a_d = a_q << k_s;
          b_d = b_q >> k_s;
        end
      end
      DONE: begin
        if (ostream_rdy) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= {W{1'b0}};
      a_q     <= {W{1'b0}};
      b_q     <= {NBITS{1'b0}};
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
    end
  end

endmodule

// File: doc/lab1_imul_int_mul_var_param.md
# lab1_imul_int_mul_var_param

Parametrised variable-latency integer multiplier; successor to the fixed 32-bit shift-add unit in lab1_imul. Accepts {mode, a, b} over a val/rdy stream and returns the full 2*NBITS-bit product, signed or unsigned per message. Each cycle it either adds one partial product or skips a run of up to MAX_SKIP zero bits in b, so latency tracks operand sparsity. Sits between the test source and sink, or in front of the processor's MUL writeback path.

## Interface
- NBITS, 32, operand width; ≥ 4.
- MAX_SKIP, 8, max zero bits of b consumed in one CALC cycle; 1 ≤ MAX_SKIP ≤ NBITS.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low: asserted when 0, sampled on posedge clk.
- istream_val  in  1  request valid.
- istream_rdy  out  1  request ready.
- istream_msg  in  2*NBITS+1  {signed_mode[2*NBITS], a[2*NBITS-1:NBITS], b[NBITS-1:0]}.
- ostream_val  out  1  response valid.
- ostream_rdy  in  1  response ready.
- ostream_msg  out  2*NBITS  full product, two's complement when signed_mode=1.

## Operation
- States: IDLE, CALC, DONE. Enum in shared package.
- IDLE: istream_rdy=1. On istream_val && istream_rdy: a_reg <= |a| zero-extended to 2*NBITS, b_reg <= |b| (NBITS bits), neg <= signed_mode & (a[MSB]^b[MSB]), acc <= 0; next CALC. Unsigned mode: magnitudes are the raw operands.
- Magnitude of -2^(NBITS-1) is 2^(NBITS-1); it fits unsigned NBITS, no special case.
- CALC, priority order:
  - b_reg == 0: acc <= neg ? (~acc + 1) : acc (mod 2^(2*NBITS)); next DONE.
  - b_reg[0] == 1: acc <= acc + a_reg; a_reg <<= 1; b_reg >>= 1; stay.
  - else: k = min(trailing_zeros(b_reg), MAX_SKIP); a_reg <<= k; b_reg >>= k; stay.
- DONE: ostream_val=1, ostream_msg=acc. On ostream_rdy: next IDLE. istream_rdy=0 (no overlap of requests).
- All arithmetic mod 2^(2*NBITS); bits shifted out of a_reg are discarded.
- ostream_msg driven from acc at all times; meaningful only when ostream_val=1.

## Timing
- Reset (reset==0 at posedge): state <= IDLE, acc <= 0, a_reg/b_reg <= 0, neg <= 0. While reset==0: istream_rdy=0, ostream_val=0. First possible accept: first cycle with reset==1.
- Reset mid-CALC or mid-DONE: in-flight transaction dropped, no response issued.
- istream_rdy, ostream_val are Moore outputs (decoded from state, gated by reset); no combinational path from val to rdy.
- Accept at posedge ending cycle t; CALC from t+1. CALC cycles = popcount(b) + Σ⌈zero_run/MAX_SKIP⌉ over zero runs below MSB one + 1 (final b==0 cycle). ostream_val asserts the cycle after that.
- Min latency (b=0): accept t, CALC t+1, ostream_val at t+2. Max (MAX_SKIP=1, b all ones): NBITS+1 CALC cycles.
- ostream_val held with stable ostream_msg until ostream_rdy; transfer at posedge with both high; IDLE (istream_rdy=1) the following cycle.
- istream_val while not in IDLE: ignored, source holds.

## Structure
- Package lab1_imul_pkg: state enum (IDLE, CALC, DONE), msg field index localparams derived from NBITS.
- Sub-module lab1_imul_tz_count #(NBITS, MAX_SKIP): combinational trailing-zero count of b_reg, saturating at MAX_SKIP, $clog2(MAX_SKIP+1) bits out.
- Adder: vc_SimpleAdder #(2*NBITS). Control FSM and datapath in one module; line trace shows state and k.

## Test plan
- Unsigned, NBITS=32, MAX_SKIP=8: a=3, b=0 -> product 0, ostream_val exactly 2 cycles after accept.
- Unsigned: a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE00000001; 33 CALC cycles.
- Skip: a=5, b=0x00000100 -> 0x500; CALC = 3 cycles (skip 8, add, zero-check).
- Signed: a=-7, b=6 -> 0xFFFFFFFFFFFFFFD6; a=0x80000000, b=0x80000000 -> 0x4000000000000000; a=-1, b=-1 -> 1.
- Sink backpressure: ostream_rdy=0 for 5 cycles in DONE -> ostream_val/msg stable, istream_rdy=0 throughout; next request accepted only after transfer.
- reset=0 for one cycle mid-CALC of a=9, b=0xF0F0 -> no response; following request a=2, b=3 -> 6.
